// File: rtl/park_gate_controller.sv
// Parking-lot gate controller: eight-space occupancy bitmap, entry/exit handshakes and a timed gate.
// Define PARK_ROUND_ROBIN_EN to alternate winners on simultaneous requests (default: exit always wins).
module park_gate_controller #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_space,
  output logic       entry_ack,
  output logic [2:0] entry_space,
  output logic       entry_reject,
  output logic       exit_ack,
  output logic       exit_error,
  output logic [7:0] occupancy,
  output logic [3:0] free_count,
  output logic       full,
  output logic       gate_open
);

  typedef enum logic [2:0] {IDLE, ENTRY, EXIT, REJECT, ERROR, GATE_HOLD} state_e;

  localparam logic [3:0] HOLD_LOAD = 4'(GATE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] occ_q, occ_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] free_idx;
  logic [3:0] zeros;
  logic       serve_exit;
  logic       entry_ack_c, entry_reject_c, exit_ack_c, exit_error_c, gate_open_c;
  logic [2:0] entry_space_c;

  // Lowest-index free space and the number of free spaces.
  always_comb begin
    free_idx = '0;
    zeros    = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!occ_q[i]) free_idx = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      zeros = zeros + {3'b000, ~occ_q[i]};
    end
  end

`ifdef PARK_ROUND_ROBIN_EN
  logic exit_next_q, exit_next_d;

  always_comb begin
    serve_exit  = exit_req && (!entry_req || exit_next_q);
    exit_next_d = exit_next_q;
    if (state_q == IDLE && entry_req && exit_req) exit_next_d = !serve_exit;
  end

  always_ff @(posedge clk) begin
    if (reset) exit_next_q <= 1'b1;
    else       exit_next_q <= exit_next_d;
  end
`else
  always_comb begin
    serve_exit = exit_req;
  end
`endif

  always_comb begin
    state_d        = state_q;
    occ_d          = occ_q;
    cnt_d          = cnt_q;
    entry_ack_c    = 1'b0;
    entry_space_c  = '0;
    entry_reject_c = 1'b0;
    exit_ack_c     = 1'b0;
    exit_error_c   = 1'b0;
    gate_open_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (serve_exit)     state_d = occ_q[exit_space] ? EXIT : ERROR;
        else if (entry_req) state_d = (&occ_q) ? REJECT : ENTRY;
      end
      ENTRY: begin
        entry_ack_c     = 1'b1;
        entry_space_c   = free_idx;
        occ_d[free_idx] = 1'b1;
        cnt_d           = HOLD_LOAD;
        state_d         = GATE_HOLD;
      end
      EXIT: begin
        exit_ack_c        = 1'b1;
        occ_d[exit_space] = 1'b0;
        cnt_d             = HOLD_LOAD;
        state_d           = GATE_HOLD;
      end
      REJECT: begin
        entry_reject_c = 1'b1;
        state_d        = IDLE;
      end
      ERROR: begin
        exit_error_c = 1'b1;
        state_d      = IDLE;
      end
      GATE_HOLD: begin
        gate_open_c = 1'b1;
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      occ_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulses and the gate are forced low while reset is held, even mid-hold.
  assign entry_ack    = entry_ack_c & ~reset;
  assign entry_space  = reset ? 3'd0 : entry_space_c;
  assign entry_reject = entry_reject_c & ~reset;
  assign exit_ack     = exit_ack_c & ~reset;
  assign exit_error   = exit_error_c & ~reset;
  assign gate_open    = gate_open_c & ~reset;
  assign occupancy    = occ_q;
  assign free_count   = zeros;
  assign full         = &occ_q;

endmodule
